// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM for the RV32I core.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It handshakes
// with the unified memory port via MemReady_in and traps on illegal opcodes
// or memory timeouts.
// Optional feature macro: CTRL_RETIRE_CNT_EN enables the 32-bit
// retired-instruction counter on InstrRet_out. When the macro is not defined,
// InstrRet_out is tied to 0.
module multicycle_control_unit #(
  parameter int ALUOP_W     = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [6:0]         Opcode_in,
  input  logic               Zero_in,
  input  logic               MemReady_in,
  output logic               PCWrite_out,
  output logic               PCSrc_out,
  output logic               IRWrite_out,
  output logic               IorD_out,
  output logic               MemRead_out,
  output logic               MemWrite_out,
  output logic               RegWrite_out,
  output logic               MemtoReg_out,
  output logic               AluSrcA_out,
  output logic [1:0]         AluSrcB_out,
  output logic [ALUOP_W-1:0] AluOp_out,
  output logic [2:0]         State_out,
  output logic               Error_out,
  output logic [31:0]        InstrRet_out
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  // A zero timeout still needs a 1-bit counter so the width stays legal.
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_error;

  logic [2:0] w_next;
  logic       w_timeout;
  logic       w_pcwrite, w_pcsrc, w_irwrite, w_iord, w_memread, w_memwrite;
  logic       w_regwrite, w_memtoreg, w_alusrca;
  logic [1:0] w_alusrcb, w_aluop;

  assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait_cnt == CNT_W'(MEM_TIMEOUT));

  // Next-state and control decode from the current state plus input gating.
  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_pcsrc    = 1'b0;
    w_irwrite  = 1'b0;
    w_iord     = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_alusrcb  = 2'b00;
    w_aluop    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_alusrcb = 2'b01;
        if (MemReady_in) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_TRAP;
        end
      end
      S_DECODE: begin
        w_alusrcb = 2'b10;
        case (Opcode_in)
          OP_R, OP_I, OP_LW, OP_SW, OP_B: w_next = S_EXEC;
          default:                        w_next = S_TRAP;
        endcase
      end
      S_EXEC: begin
        w_alusrca = 1'b1;
        case (Opcode_in)
          OP_R: begin
            w_aluop = 2'b10;
            w_next  = S_WB;
          end
          OP_I: begin
            w_alusrcb = 2'b10;
            w_aluop   = 2'b11;
            w_next    = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alusrcb = 2'b10;
            w_next    = S_MEM;
          end
          OP_B: begin
            w_aluop   = 2'b01;
            w_pcsrc   = 1'b1;
            w_pcwrite = Zero_in;
            w_next    = S_FETCH;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_MEM: begin
        w_iord = 1'b1;
        case (Opcode_in)
          OP_LW: begin
            w_memread = 1'b1;
            if (MemReady_in)    w_next = S_WB;
            else if (w_timeout) w_next = S_TRAP;
          end
          OP_SW: begin
            w_memwrite = 1'b1;
            if (MemReady_in)    w_next = S_FETCH;
            else if (w_timeout) w_next = S_TRAP;
          end
          default: w_next = S_TRAP;
        endcase
      end
      S_WB: begin
        w_regwrite = 1'b1;
        w_memtoreg = (Opcode_in != OP_LW);
        w_next     = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_TRAP;
    endcase
  end

  // State register and sticky trap flag.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= S_FETCH;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= r_error | (w_next == S_TRAP);
    end
  end

  // Memory wait counter. It counts only while the FSM stays in FETCH/MEM
  // without ready. Any state change or any ready clears it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wait_cnt <= '0;
    end else if ((MEM_TIMEOUT != 0) && (w_next == r_state) && !MemReady_in &&
                 ((r_state == S_FETCH) || (r_state == S_MEM))) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic        w_retire;
  logic [31:0] r_instret;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB));

  // Retired-instruction counter. It wraps naturally and holds in TRAP
  // because TRAP never re-enters FETCH.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign InstrRet_out = r_instret;
`else
  assign InstrRet_out = '0;
`endif

  // Strobes are gated by reset so they drop asynchronously while it is held.
  assign PCWrite_out  = rst_n_in & w_pcwrite;
  assign PCSrc_out    = rst_n_in & w_pcsrc;
  assign IRWrite_out  = rst_n_in & w_irwrite;
  assign IorD_out     = rst_n_in & w_iord;
  assign MemRead_out  = rst_n_in & w_memread;
  assign MemWrite_out = rst_n_in & w_memwrite;
  assign RegWrite_out = rst_n_in & w_regwrite;
  assign MemtoReg_out = rst_n_in & w_memtoreg;
  assign AluSrcA_out  = rst_n_in & w_alusrca;
  assign AluSrcB_out  = w_alusrcb & {2{rst_n_in}};
  assign AluOp_out    = ALUOP_W'(w_aluop) & {ALUOP_W{rst_n_in}};
  assign State_out    = r_state;
  assign Error_out    = r_error;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit.
// u_dut uses the default parameters. u_t3 uses MEM_TIMEOUT=3 and ALUOP_W=3.
module tb_multicycle_control_unit;

`ifdef CTRL_RETIRE_CNT_EN
  localparam bit RET_EN = 1'b1;
`else
  localparam bit RET_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  // ctl = {PCWrite,PCSrc,IRWrite,IorD,MemRead,MemWrite,RegWrite,MemtoReg,AluSrcA,AluSrcB[1:0],AluOp[1:0]}
  localparam logic [12:0] C_ZERO   = 13'b0_0_0_0_0_0_0_0_0_00_00;
  localparam logic [12:0] C_FETCH  = 13'b0_0_0_0_1_0_0_0_0_01_00;
  localparam logic [12:0] C_F_RDY  = 13'b1_0_1_0_1_0_0_0_0_01_00;
  localparam logic [12:0] C_DEC    = 13'b0_0_0_0_0_0_0_0_0_10_00;
  localparam logic [12:0] C_EX_R   = 13'b0_0_0_0_0_0_0_0_1_00_10;
  localparam logic [12:0] C_EX_I   = 13'b0_0_0_0_0_0_0_0_1_10_11;
  localparam logic [12:0] C_EX_M   = 13'b0_0_0_0_0_0_0_0_1_10_00;
  localparam logic [12:0] C_EX_BT  = 13'b1_1_0_0_0_0_0_0_1_00_01;
  localparam logic [12:0] C_EX_BN  = 13'b0_1_0_0_0_0_0_0_1_00_01;
  localparam logic [12:0] C_MEM_LW = 13'b0_0_0_1_1_0_0_0_0_00_00;
  localparam logic [12:0] C_MEM_SW = 13'b0_0_0_1_0_1_0_0_0_00_00;
  localparam logic [12:0] C_WB_ALU = 13'b0_0_0_0_0_0_1_1_0_00_00;
  localparam logic [12:0] C_WB_LW  = 13'b0_0_0_0_0_0_1_0_0_00_00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst_n, zero, rdy;
  logic [6:0]  op;
  logic        pcw, pcs, irw, iord, mr, mw, rw, m2r, asa, err;
  logic [1:0]  asb, aop;
  logic [2:0]  st;
  logic [31:0] ret;
  logic [12:0] ctl;
  assign ctl = {pcw, pcs, irw, iord, mr, mw, rw, m2r, asa, asb, aop};

  // short-timeout instance
  logic        t_rst_n, t_zero, t_rdy;
  logic [6:0]  t_op;
  logic        t_pcw, t_pcs, t_irw, t_iord, t_mr, t_mw, t_rw, t_m2r, t_asa, t_err;
  logic [1:0]  t_asb;
  logic [2:0]  t_aop;
  logic [2:0]  t_st;
  logic [31:0] t_ret;
  logic [12:0] t_ctl;
  assign t_ctl = {t_pcw, t_pcs, t_irw, t_iord, t_mr, t_mw, t_rw, t_m2r, t_asa, t_asb, t_aop[1:0]};

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_ret = '0;

  multicycle_control_unit u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .Opcode_in(op), .Zero_in(zero), .MemReady_in(rdy),
    .PCWrite_out(pcw), .PCSrc_out(pcs), .IRWrite_out(irw), .IorD_out(iord),
    .MemRead_out(mr), .MemWrite_out(mw), .RegWrite_out(rw), .MemtoReg_out(m2r),
    .AluSrcA_out(asa), .AluSrcB_out(asb), .AluOp_out(aop), .State_out(st),
    .Error_out(err), .InstrRet_out(ret)
  );

  multicycle_control_unit #(.ALUOP_W(3), .MEM_TIMEOUT(3)) u_t3 (
    .clk_in(clk), .rst_n_in(t_rst_n), .Opcode_in(t_op), .Zero_in(t_zero), .MemReady_in(t_rdy),
    .PCWrite_out(t_pcw), .PCSrc_out(t_pcs), .IRWrite_out(t_irw), .IorD_out(t_iord),
    .MemRead_out(t_mr), .MemWrite_out(t_mw), .RegWrite_out(t_rw), .MemtoReg_out(t_m2r),
    .AluSrcA_out(t_asa), .AluSrcB_out(t_asb), .AluOp_out(t_aop), .State_out(t_st),
    .Error_out(t_err), .InstrRet_out(t_ret)
  );

  task automatic test_reset();
    rst_n = 1'b0; t_rst_n = 1'b0;
    rdy = 1'b1; op = OP_R; zero = 1'b0;
    t_rdy = 1'b0; t_op = OP_R; t_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({st, ctl, err, ret} !== {3'd0, C_ZERO, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL reset: st=%0d ctl=%b err=%b ret=%0d, expected st=0 ctl=%b err=0 ret=0",
               st, ctl, err, ret, C_ZERO);
    end
    n_cmp++;
    if ({t_st, t_ctl, t_aop[2], t_err} !== {3'd0, C_ZERO, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_t3: st=%0d ctl=%b err=%b, expected st=0 ctl=%b err=0",
               t_st, t_ctl, t_err, C_ZERO);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic        r  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [12:0] ec [5] = '{C_F_RDY, C_DEC, C_EX_R, C_WB_ALU, C_FETCH};
    op = OP_R;
    for (int i = 0; i < 5; i++) begin
      rdy = r[i]; #1;
      n_cmp++;
      if ({st, ctl} !== {es[i], ec[i]}) begin
        n_err++;
        $display("FAIL rtype cyc%0d: st=%0d ctl=%b, expected st=%0d ctl=%b", i, st, ctl, es[i], ec[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    exp_ret += 32'(RET_EN);
    n_cmp++;
    if (ret !== exp_ret) begin
      n_err++;
      $display("FAIL rtype_retire: ret=%0d, expected %0d", ret, exp_ret);
    end
  endtask

  task automatic test_load_wait();
    logic        r  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  es [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
    logic [12:0] ec [8] = '{C_F_RDY, C_DEC, C_EX_M, C_MEM_LW, C_MEM_LW, C_MEM_LW, C_WB_LW, C_FETCH};
    op = OP_LW;
    for (int i = 0; i < 8; i++) begin
      rdy = r[i]; #1;
      n_cmp++;
      if ({st, ctl} !== {es[i], ec[i]}) begin
        n_err++;
        $display("FAIL load cyc%0d: st=%0d ctl=%b, expected st=%0d ctl=%b", i, st, ctl, es[i], ec[i]);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
    exp_ret += 32'(RET_EN);
    n_cmp++;
    if (ret !== exp_ret) begin
      n_err++;
      $display("FAIL load_retire: ret=%0d, expected %0d", ret, exp_ret);
    end
  endtask

  task automatic test_store_fetch_wait();
    logic        r  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  es [7] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [12:0] ec [7] = '{C_FETCH, C_FETCH, C_F_RDY, C_DEC, C_EX_M, C_MEM_SW, C_FETCH};
    op = OP_SW;
    for (int i = 0; i < 7; i++) begin
      rdy = r[i]; #1;
      n_cmp++;
      if ({st, ctl} !== {es[i], ec[i]}) begin
        n_err++;
        $display("FAIL store cyc%0d: st=%0d ctl=%b, expected st=%0d ctl=%b", i, st, ctl, es[i], ec[i]);
      end
      if (i < 6) begin @(posedge clk); #1; end
    end
    exp_ret += 32'(RET_EN);
  endtask

  task automatic test_itype();
    logic        r  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [12:0] ec [5] = '{C_F_RDY, C_DEC, C_EX_I, C_WB_ALU, C_FETCH};
    op = OP_I;
    for (int i = 0; i < 5; i++) begin
      rdy = r[i]; #1;
      n_cmp++;
      if ({st, ctl} !== {es[i], ec[i]}) begin
        n_err++;
        $display("FAIL itype cyc%0d: st=%0d ctl=%b, expected st=%0d ctl=%b", i, st, ctl, es[i], ec[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    exp_ret += 32'(RET_EN);
  endtask

  task automatic test_branch();
    logic        r  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        z  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    logic [12:0] ec [7] = '{C_F_RDY, C_DEC, C_EX_BT, C_F_RDY, C_DEC, C_EX_BN, C_FETCH};
    op = OP_B;
    for (int i = 0; i < 7; i++) begin
      rdy = r[i]; zero = z[i]; #1;
      n_cmp++;
      if ({st, ctl} !== {es[i], ec[i]}) begin
        n_err++;
        $display("FAIL branch cyc%0d: st=%0d ctl=%b, expected st=%0d ctl=%b", i, st, ctl, es[i], ec[i]);
      end
      if (i < 6) begin @(posedge clk); #1; end
    end
    exp_ret += 32'(RET_EN) * 32'd2;
    n_cmp++;
    if (ret !== exp_ret) begin
      n_err++;
      $display("FAIL branch_retire: ret=%0d, expected %0d", ret, exp_ret);
    end
  endtask

  task automatic test_illegal();
    logic [2:0]  es [5] = '{3'd0, 3'd1, 3'd5, 3'd5, 3'd5};
    logic [12:0] ec [5] = '{C_F_RDY, C_DEC, C_ZERO, C_ZERO, C_ZERO};
    logic        ee [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    op = 7'b1111111;
    rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({st, ctl, err, ret} !== {es[i], ec[i], ee[i], exp_ret}) begin
        n_err++;
        $display("FAIL illegal cyc%0d: st=%0d ctl=%b err=%b ret=%0d, expected st=%0d ctl=%b err=%b ret=%0d",
                 i, st, ctl, err, ret, es[i], ec[i], ee[i], exp_ret);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0; #1;
    exp_ret = '0;
    n_cmp++;
    if ({st, ctl, err, ret} !== {3'd0, C_ZERO, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL illegal_reset: st=%0d ctl=%b err=%b ret=%0d, expected st=0 ctl=0 err=0 ret=0",
               st, ctl, err, ret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; rdy = 1'b0;
  endtask

  task automatic test_reset_mid_mem();
    logic        r  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [12:0] ec [4] = '{C_F_RDY, C_DEC, C_EX_M, C_MEM_SW};
    op = OP_SW;
    for (int i = 0; i < 4; i++) begin
      rdy = r[i]; #1;
      n_cmp++;
      if ({st, ctl} !== {es[i], ec[i]}) begin
        n_err++;
        $display("FAIL midmem cyc%0d: st=%0d ctl=%b, expected st=%0d ctl=%b", i, st, ctl, es[i], ec[i]);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({mw, st, ctl, err, ret} !== {1'b0, 3'd0, C_ZERO, 1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL midmem_async: mw=%b st=%0d ctl=%b err=%b ret=%0d, expected mw=0 st=0 ctl=0 err=0 ret=0",
               mw, st, ctl, err, ret);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({st, ctl, err, ret} !== {3'd0, C_FETCH, 1'b0, 32'd0}) begin
        n_err++;
        $display("FAIL midmem_release cyc%0d: st=%0d ctl=%b err=%b ret=%0d, expected st=0 ctl=%b err=0 ret=0",
                 i, st, ctl, err, ret, C_FETCH);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_timeout();
    logic [2:0]  es [5] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd5};
    logic [12:0] ec [5] = '{C_FETCH, C_FETCH, C_FETCH, C_FETCH, C_ZERO};
    logic        ee [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_op = OP_R; t_rdy = 1'b0;
    t_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({t_st, t_ctl, t_err} !== {es[i], ec[i], ee[i]}) begin
        n_err++;
        $display("FAIL fetch_timeout cyc%0d: st=%0d ctl=%b err=%b, expected st=%0d ctl=%b err=%b",
                 i, t_st, t_ctl, t_err, es[i], ec[i], ee[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    t_rst_n = 1'b0; #1;
    n_cmp++;
    if ({t_st, t_err} !== {3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL fetch_timeout_reset: st=%0d err=%b, expected st=0 err=0", t_st, t_err);
    end
    @(posedge clk); #1;
    t_rst_n = 1'b1;
  endtask

  task automatic test_ready_at_limit();
    logic        r  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    logic [12:0] ec [8] = '{C_FETCH, C_FETCH, C_FETCH, C_F_RDY, C_DEC, C_EX_R, C_WB_ALU, C_FETCH};
    t_op = OP_R;
    for (int i = 0; i < 8; i++) begin
      t_rdy = r[i]; #1;
      n_cmp++;
      if ({t_st, t_ctl, t_err} !== {es[i], ec[i], 1'b0}) begin
        n_err++;
        $display("FAIL ready_at_limit cyc%0d: st=%0d ctl=%b err=%b, expected st=%0d ctl=%b err=0",
                 i, t_st, t_ctl, t_err, es[i], ec[i]);
      end
      if (i == 5) begin
        n_cmp++;
        if (t_aop !== 3'b010) begin
          n_err++;
          $display("FAIL aluop_wide: aluop=%b, expected 010", t_aop);
        end
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (t_ret !== 32'(RET_EN)) begin
      n_err++;
      $display("FAIL t3_retire: ret=%0d, expected %0d", t_ret, 32'(RET_EN));
    end
  endtask

  task automatic test_mem_timeout();
    logic        r  [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0]  es [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5};
    logic [12:0] ec [8] = '{C_F_RDY, C_DEC, C_EX_M, C_MEM_LW, C_MEM_LW, C_MEM_LW, C_MEM_LW, C_ZERO};
    logic        ee [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    t_op = OP_LW;
    for (int i = 0; i < 8; i++) begin
      t_rdy = r[i]; #1;
      n_cmp++;
      if ({t_st, t_ctl, t_err} !== {es[i], ec[i], ee[i]}) begin
        n_err++;
        $display("FAIL mem_timeout cyc%0d: st=%0d ctl=%b err=%b, expected st=%0d ctl=%b err=%b",
                 i, t_st, t_ctl, t_err, es[i], ec[i], ee[i]);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_fetch_wait();
    test_itype();
    test_branch();
    test_illegal();
    test_reset_mid_mem();
    test_fetch_timeout();
    test_ready_at_limit();
    test_mem_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
